// File: rtl/cmp_tally.sv
// cmp_tally: tallies comparator flag samples over a window of WINDOW accepted
// samples, then holds the per-flag counts until the consumer takes them.
// Build option: define CMP_TALLY_ONEHOT_CHK_EN to classify non-one-hot
// {x,y,z} samples as errors instead of counting each asserted flag.
module cmp_tally #(
   parameter int unsigned WINDOW = 16,
   parameter int unsigned CNT_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_x,
   output logic [CNT_W-1:0] cnt_y,
   output logic [CNT_W-1:0] cnt_z,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

   localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] smp_q, smp_d;
   logic [CNT_W-1:0] cx_q, cx_d;
   logic [CNT_W-1:0] cy_q, cy_d;
   logic [CNT_W-1:0] cz_q, cz_d;
   logic [CNT_W-1:0] ce_q, ce_d;
   logic             accept;
   logic             inc_x, inc_y, inc_z, inc_e;

   // Per-sample increment decode; gated by accept so idle cycles change nothing.
   always_comb begin
      inc_x = 1'b0;
      inc_y = 1'b0;
      inc_z = 1'b0;
      inc_e = 1'b0;
`ifdef CMP_TALLY_ONEHOT_CHK_EN
      // Exactly one flag set: odd parity and not all three.
      if ((x ^ y ^ z) && !(x && y && z)) begin
         inc_x = x;
         inc_y = y;
         inc_z = z;
      end else begin
         inc_e = 1'b1;
      end
`else
      inc_x = x;
      inc_y = y;
      inc_z = z;
`endif
   end

   // Next-state, counter updates and handshake outputs.
   always_comb begin
      state_d   = state_q;
      smp_d     = smp_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      cz_d      = cz_q;
      ce_d      = ce_q;
      in_ready  = (state_q != StHold);
      out_valid = (state_q == StHold);
      busy      = (state_q != StIdle);
      accept    = in_valid && in_ready;
      unique case (state_q)
         StIdle, StAcc: begin
            if (accept) begin
               smp_d = smp_q + 1'b1;
               cx_d  = cx_q + {{(CNT_W-1){1'b0}}, inc_x};
               cy_d  = cy_q + {{(CNT_W-1){1'b0}}, inc_y};
               cz_d  = cz_q + {{(CNT_W-1){1'b0}}, inc_z};
               ce_d  = ce_q + {{(CNT_W-1){1'b0}}, inc_e};
               state_d = (smp_d == WinLast) ? StHold : StAcc;
            end
         end
         StHold: begin
            if (out_ready) begin
               smp_d   = '0;
               cx_d    = '0;
               cy_d    = '0;
               cz_d    = '0;
               ce_d    = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers; reset discards any partial or pending tally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         smp_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         cz_q    <= '0;
         ce_q    <= '0;
      end else begin
         state_q <= state_d;
         smp_q   <= smp_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         cz_q    <= cz_d;
         ce_q    <= ce_d;
      end
   end

   assign cnt_x   = cx_q;
   assign cnt_y   = cy_q;
   assign cnt_z   = cz_q;
   assign err_cnt = ce_q;

endmodule

// File: doc/cmp_tally.md
CMP_TALLY -- requirements
Module: cmp_tally

Interface
REQ-001 Parameter: WINDOW, default 16, number of accepted comparator samples per tally window (2..255).
REQ-002 Parameter: CNT_W, default 5, count output width; SHALL satisfy 2**CNT_W > WINDOW.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  comparator sample present this cycle.
REQ-006 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-007 Port: x  input  1  comparator flag "a side greater".
REQ-008 Port: y  input  1  comparator flag "b side greater".
REQ-009 Port: z  input  1  comparator flag "equal".
REQ-010 Port: out_valid  output  1  tally result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: cnt_x, cnt_y, cnt_z  output  CNT_W each  per-flag counts for the completed window.
REQ-013 Port: err_cnt  output  CNT_W  count of non-one-hot samples in the completed window.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 A sample SHALL be accepted exactly on cycles where in_valid and in_ready are both 1.
REQ-016 FSM states SHALL be IDLE, ACC, HOLD.
REQ-017 IDLE: in_ready=1; on accepted sample, count it, sample counter=1, go to ACC.
REQ-018 ACC: in_ready=1; each accepted sample increments the sample counter; on the accepted sample that makes the counter equal to WINDOW, go to HOLD.
REQ-019 ACC with in_valid=0 SHALL hold all counters and state (no timeout).
REQ-020 HOLD: in_ready=0, out_valid=1, cnt_x/cnt_y/cnt_z/err_cnt stable until handshake.
REQ-021 HOLD with out_valid and out_ready both 1: clear all counters, go to IDLE next cycle; in_valid in that cycle is NOT accepted.
REQ-022 out_valid SHALL rise the cycle after the WINDOW-th accepted sample (latency 1).
REQ-023 Outputs cnt_*/err_cnt SHALL reflect live running counts in IDLE/ACC; consumer may only rely on them while out_valid=1.
REQ-024 Sum cnt_x+cnt_y+cnt_z+err_cnt SHALL equal WINDOW when out_valid=1 (check mode enabled).
REQ-025 out_ready asserted outside HOLD SHALL have no effect.
REQ-026 Counters SHALL never wrap; width rule REQ-002 guarantees headroom.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, all counters 0, out_valid=0, busy=0, in_ready=1 while deasserted state resumes.
REQ-028 Reset mid-window or mid-HOLD SHALL discard the partial/pending tally; no result emitted.
REQ-029 First sample SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro CMP_TALLY_ONEHOT_CHK_EN defined: sample with {x,y,z} not exactly one-hot (000, 011, 101, 110, 111) SHALL increment err_cnt only; one-hot samples increment matching cnt_*.
REQ-031 Macro CMP_TALLY_ONEHOT_CHK_EN undefined: err_cnt SHALL be constant 0; each asserted flag increments its own count independently (000 counts window slot only).

Verification
REQ-032 WINDOW=4, CHK_EN: samples xyz=100,100,010,001 back-to-back, out_ready=1 -> out_valid one cycle after 4th, cnt_x=2, cnt_y=1, cnt_z=1, err_cnt=0, IDLE next cycle.
REQ-033 WINDOW=4, CHK_EN: samples 000,110,001,001 -> cnt_z=2, err_cnt=2, cnt_x=cnt_y=0.
REQ-034 WINDOW=4: complete window, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no sample accepted; out_ready=1 -> IDLE, counts 0.
REQ-035 WINDOW=4: gaps of in_valid=0 between samples -> result identical to gapless run, out_valid after 4th accepted sample only.
REQ-036 WINDOW=4: assert rst after 3rd sample -> all outputs 0 immediately; next 4 samples 001 -> cnt_z=4.
REQ-037 WINDOW=4, CHK_EN undefined: samples 111,100,000,001 -> cnt_x=2, cnt_y=1, cnt_z=2, err_cnt=0.
